// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM port between instruction fetch (read-only) and the load/store unit.
// Latency: a request seen in IDLE at cycle T is acked at T+2+WAIT_STATES; one access per 3+WAIT_STATES cycles.
// Backpressure: i_stall/d_stall hold each requester until its one-cycle ack; requests are latched in IDLE only.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst_n,

   // instruction fetch side
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,

   // load/store side
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,

   // SRAM port
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Wait-state counter is 4 bits wide, covering WAIT_STATES 0..15.
   localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_STATES);

   state_t     state;
   logic       owner;       // 1 = load/store owns the current access, 0 = fetch
   logic [3:0] wait_cnt;
   logic       grant_data;  // arbitration result, meaningful only in IDLE with a request pending
   logic       sel_we;      // write strobe of the winning request

`ifdef MEM_ARB_RR_EN
   logic last_data;         // 1 = load/store won the most recent grant

   // Round-robin: with both requesting, serve the side that was not served last
   always_comb begin
      grant_data = d_req;
      if (d_req && i_req) begin
         grant_data = ~last_data;
      end
   end

   // Track the winner of every grant made in IDLE; reset favours fetch next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_data <= 1'b1;
      end else if (state == ST_IDLE && (i_req || d_req)) begin
         last_data <= grant_data;
      end
   end
`else
   // Fixed priority: a pending load/store belongs to an older instruction, so it wins
   always_comb grant_data = d_req;
`endif

   // Fetch is read-only, so only a data grant can produce a write
   always_comb sel_we = grant_data & d_we;

   // Stalls drop in the ack cycle so the requester can advance on the same edge
   always_comb begin
      i_stall = i_req & ~i_ack;
      d_stall = d_req & ~d_ack;
   end

   // Access sequencer: latch the winner in IDLE, drive SRAM in ACCESS, pulse ack in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= 1'b0;
         wait_cnt  <= 4'd0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         sram_cs   <= 1'b0;
         sram_oe   <= 1'b0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  state     <= ST_ACCESS;
                  owner     <= grant_data;
                  wait_cnt  <= WAIT_CNT_INIT;
                  sram_cs   <= 1'b1;
                  sram_we   <= sel_we;
                  sram_oe   <= ~sel_we;
                  sram_addr <= grant_data ? d_addr : i_addr;
                  sram_din  <= sel_we ? d_wdata : '0;
               end
            end

            ST_ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  // SRAM outputs stay put while the wait states elapse
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  if (owner) begin
                     d_ack <= 1'b1;
                     // stores leave the last load word untouched
                     if (!sram_we) begin
                        d_rdata <= sram_dout;
                     end
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= sram_dout;
                  end
                  sram_cs   <= 1'b0;
                  sram_oe   <= 1'b0;
                  sram_we   <= 1'b0;
                  sram_addr <= '0;
                  sram_din  <= '0;
                  state     <= ST_DONE;
               end
            end

            ST_DONE: begin
               // The acked requester still shows req this cycle; ignore it so it is not regranted
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the SRAM port arbiter with hand-computed expectations.
// Two instances: WAIT_STATES=0 for the main scenarios, WAIT_STATES=3 for the stretched access.
// Round-robin expectations are selected when MEM_ARB_RR_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // instance with no wait states
   logic        i_req, i_ack, i_stall;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ack, d_stall;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        sram_cs, sram_oe, sram_we;
   logic [31:0] sram_addr, sram_din, sram_dout;

   // instance with three wait states
   logic        w_i_req, w_i_ack, w_i_stall;
   logic [31:0] w_i_addr, w_i_rdata;
   logic        w_d_req, w_d_we, w_d_ack, w_d_stall;
   logic [31:0] w_d_addr, w_d_wdata, w_d_rdata;
   logic        w_sram_cs, w_sram_oe, w_sram_we;
   logic [31:0] w_sram_addr, w_sram_din, w_sram_dout;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(3)) dut_ws (
      .clk(clk), .rst_n(rst_n),
      .i_req(w_i_req), .i_addr(w_i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata), .i_stall(w_i_stall),
      .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_wdata(w_d_wdata),
      .d_ack(w_d_ack), .d_rdata(w_d_rdata), .d_stall(w_d_stall),
      .sram_cs(w_sram_cs), .sram_oe(w_sram_oe), .sram_we(w_sram_we),
      .sram_addr(w_sram_addr), .sram_din(w_sram_din), .sram_dout(w_sram_dout)
   );

   // SRAM models: combinational read, write on the clock edge; preload shares the write path
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   logic        pl_en, pl_sel;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) begin
         if (pl_sel) mem_b[pl_addr] <= pl_data;
         else        mem_a[pl_addr] <= pl_data;
      end else begin
         if (sram_cs && sram_we)     mem_a[sram_addr[7:0]]   <= sram_din;
         if (w_sram_cs && w_sram_we) mem_b[w_sram_addr[7:0]] <= w_sram_din;
      end
   end

   assign sram_dout   = mem_a[sram_addr[7:0]];
   assign w_sram_dout = mem_b[w_sram_addr[7:0]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // move to just after the next rising edge, where inputs are changed
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic sel, input logic [7:0] addr, input logic [31:0] data);
      pl_en   = 1'b1;
      pl_sel  = sel;
      pl_addr = addr;
      pl_data = data;
      tick;
      pl_en   = 1'b0;
   endtask

   // called just after a rising edge (cycle 0); returns the cycle index of the ack, or -1 on timeout
   task automatic wait_ack(input logic is_data, output int cyc);
      logic hit;
      cyc = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         hit = is_data ? d_ack : i_ack;
         if (hit) begin
            cyc = k;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int cyc, ia, da, both, cs_n, bad, wa, ack_seen;

      rst_n   = 1'b0;
      i_req   = 1'b0; i_addr = '0;
      d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      w_i_req = 1'b0; w_i_addr = '0;
      w_d_req = 1'b0; w_d_we = 1'b0; w_d_addr = '0; w_d_wdata = '0;
      pl_en   = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;

      preload(1'b0, 8'h10, 32'h8C220004);
      preload(1'b0, 8'h20, 32'h11112222);
      preload(1'b0, 8'h30, 32'h33334444);
      preload(1'b0, 8'h50, 32'hAAAAAAAA);
      preload(1'b1, 8'h24, 32'hCAFEF00D);

      // reset state
      @(negedge clk);
      check("rst_ctrl", 32'({sram_cs, sram_oe, sram_we, i_ack, d_ack, i_stall, d_stall}), 32'd0);
      check("rst_addr", sram_addr, 32'd0);
      check("rst_din", sram_din, 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_ws_ctrl", 32'({w_sram_cs, w_sram_oe, w_sram_we, w_i_ack, w_d_ack}), 32'd0);
      tick;
      rst_n = 1'b1;
      tick;

      // single fetch: cycle 0 request, cycle 1 ACCESS, cycle 2 ack
      i_addr = 32'h10;
      i_req  = 1'b1;
      @(negedge clk);
      check("f_c0_stall", 32'(i_stall), 32'd1);
      check("f_c0_cs", 32'(sram_cs), 32'd0);
      tick; @(negedge clk);
      check("f_c1_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'b110);
      check("f_c1_addr", sram_addr, 32'h10);
      check("f_c1_stall", 32'({i_stall, i_ack}), 32'b10);
      tick; @(negedge clk);
      check("f_c2_ack", 32'({i_ack, d_ack}), 32'b10);
      check("f_c2_rdata", i_rdata, 32'h8C220004);
      check("f_c2_stall", 32'(i_stall), 32'd0);
      check("f_c2_cs", 32'(sram_cs), 32'd0);
      i_req = 1'b0;
      tick; @(negedge clk);
      check("f_c3_ack", 32'(i_ack), 32'd0);
      check("f_c3_rdata", i_rdata, 32'h8C220004);
      tick;

      // store then load back from the same address
      d_we    = 1'b1;
      d_addr  = 32'h40;
      d_wdata = 32'hDEADBEEF;
      d_req   = 1'b1;
      tick; @(negedge clk);
      check("st_c1_ctl", 32'({sram_cs, sram_oe, sram_we}), 32'b101);
      check("st_c1_din", sram_din, 32'hDEADBEEF);
      check("st_c1_addr", sram_addr, 32'h40);
      tick; @(negedge clk);
      check("st_c2_ack", 32'({i_ack, d_ack}), 32'b01);
      check("st_rdata_kept", d_rdata, 32'd0);
      check("st_c2_we", 32'(sram_we), 32'd0);
      tick;
      d_we = 1'b0;
      wait_ack(1'b1, cyc);
      check("ld_lat", cyc, 32'd2);
      check("ld_rdata", d_rdata, 32'hDEADBEEF);
      d_req = 1'b0;
      tick; tick;

      // simultaneous fetch and load
      i_addr = 32'h20;
      d_addr = 32'h30;
      d_we   = 1'b0;
      i_req  = 1'b1;
      d_req  = 1'b1;
      ia = -1; da = -1; both = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (i_ack && d_ack) both++;
         if (i_ack && ia < 0) begin ia = k; i_req = 1'b0; end
         if (d_ack && da < 0) begin da = k; d_req = 1'b0; end
         tick;
      end
`ifdef MEM_ARB_RR_EN
      check("sim_i_ack_cyc", ia, 32'd2);
      check("sim_d_ack_cyc", da, 32'd5);
`else
      check("sim_d_ack_cyc", da, 32'd2);
      check("sim_i_ack_cyc", ia, 32'd5);
`endif
      check("sim_overlap", both, 32'd0);
      check("sim_i_rdata", i_rdata, 32'h11112222);
      check("sim_d_rdata", d_rdata, 32'h33334444);

      // three wait states: ACCESS spans cycles 1..4, ack in cycle 5
      w_i_addr = 32'h24;
      w_i_req  = 1'b1;
      cs_n = 0; bad = 0; wa = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (w_sram_cs) begin
            cs_n++;
            if (w_sram_addr !== 32'h24 || w_sram_oe !== 1'b1 || w_sram_we !== 1'b0 || w_sram_din !== 32'd0) bad++;
         end
         if (w_i_ack && wa < 0) begin wa = k; w_i_req = 1'b0; end
         tick;
      end
      check("ws_cs_cycles", cs_n, 32'd4);
      check("ws_sram_stable", bad, 32'd0);
      check("ws_ack_cyc", wa, 32'd5);
      check("ws_rdata", w_i_rdata, 32'hCAFEF00D);
      check("ws_idle", 32'({w_i_stall, w_d_ack, w_d_stall, w_sram_cs}), 32'd0);
      check("ws_d_rdata", w_d_rdata, 32'd0);

      // reset pulled during the ACCESS of a store
      d_we    = 1'b1;
      d_addr  = 32'h50;
      d_wdata = 32'h12345678;
      d_req   = 1'b1;
      tick; @(negedge clk);
      check("rs_c1_we", 32'(sram_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rs_sram_off", 32'({sram_cs, sram_oe, sram_we}), 32'd0);
      check("rs_addr_off", sram_addr, 32'd0);
      check("rs_din_off", sram_din, 32'd0);
      ack_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (d_ack) ack_seen++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_ack(1'b1, cyc);
      check("rs_no_ack", ack_seen, 32'd0);
      check("rs_reissue_lat", cyc, 32'd2);
      check("rs_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      tick; tick;
      check("rs_mem", mem_a[8'h50], 32'h12345678);

      // fetch request held through its ack: no regrant in DONE, next ack three cycles later
      i_addr = 32'h10;
      i_req  = 1'b1;
      wait_ack(1'b0, cyc);
      check("hold_lat1", cyc, 32'd2);
      tick; @(negedge clk);
      check("hold_no_regrant", 32'({sram_cs, i_ack}), 32'd0);
      tick;
      wait_ack(1'b0, cyc);
      check("hold_lat2", cyc, 32'd1);
      check("hold_rdata", i_rdata, 32'h8C220004);
      i_req = 1'b0;
      tick; tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
